// File: rtl/sram_arb_pkg.sv
// Shared types and widths for the SRAM access arbiter.
//   SRAM_ADDR_W / SRAM_DATA_W : external SRAM port widths
//   arb_state_t               : arbiter ownership states
//   rd_tag_t                  : one stage of the read-return tag pipeline
package sram_arb_pkg;

    localparam int SRAM_ADDR_W = 18;
    localparam int SRAM_DATA_W = 16;

    typedef enum logic {
        S_ARB_IDLE = 1'b0,
        S_ARB_OWN  = 1'b1
    } arb_state_t;

    typedef struct packed {
        logic       valid;
        logic [2:0] idx;
    } rd_tag_t;

endpackage

// File: rtl/sram_arb_rr_pick.sv
// Combinational round-robin picker.
//   req_i  : request vector
//   ptr_i  : index of the last served requester; search starts just after it
//   pick_o : one-hot winner
//   idx_o  : index of the winner
//   any_o  : at least one request present
module sram_arb_rr_pick #(
    parameter int NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [2:0]         ptr_i,
    output logic [NUM_REQ-1:0] pick_o,
    output logic [2:0]         idx_o,
    output logic               any_o
);

    // Walk from the farthest candidate to the nearest so that the nearest
    // requester after the pointer is the last (winning) assignment.
    always_comb begin
        pick_o = '0;
        idx_o  = '0;
        any_o  = 1'b0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            if (req_i[(int'(ptr_i) + k) % NUM_REQ]) begin
                pick_o = '0;
                pick_o[(int'(ptr_i) + k) % NUM_REQ] = 1'b1;
                idx_o  = 3'((int'(ptr_i) + k) % NUM_REQ);
                any_o  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/sram_access_arbiter.sv
// Shares one external SRAM port among NUM_REQ requesters with round-robin
// ownership and bounded bursts.
//
// state      | meaning
// S_ARB_IDLE | no owner; first request after the pointer is granted at once
// S_ARB_OWN  | owner held; keeps granting until it drops or its burst expires
//
// Ports:
//   Clock, Reset            : clock, synchronous active-high reset
//   req_i/we_n_i            : per-requester access request and write enable (low = write)
//   addr_i/wdata_i          : per-requester address/data, packed requester 0 in the LSBs
//   grant_o                 : one-hot combinational grant for this cycle
//   rvalid_o/rdata_o        : read return, READ_LATENCY cycles after the grant
//   owner_o                 : current owner index
//   SRAM_address_o/SRAM_write_data_o/SRAM_we_n_o : registered SRAM command
//   SRAM_read_data_i        : read data from the SRAM controller
module sram_access_arbiter
    import sram_arb_pkg::*;
#(
    parameter int NUM_REQ      = 4,
    parameter int MAX_BURST    = 8,
    parameter int READ_LATENCY = 3
) (
    input  logic                           Clock,
    input  logic                           Reset,
    input  logic [NUM_REQ-1:0]             req_i,
    input  logic [NUM_REQ-1:0]             we_n_i,
    input  logic [NUM_REQ*SRAM_ADDR_W-1:0] addr_i,
    input  logic [NUM_REQ*SRAM_DATA_W-1:0] wdata_i,
    output logic [NUM_REQ-1:0]             grant_o,
    output logic [NUM_REQ-1:0]             rvalid_o,
    output logic [SRAM_DATA_W-1:0]         rdata_o,
    output logic [2:0]                     owner_o,
    output logic [SRAM_ADDR_W-1:0]         SRAM_address_o,
    output logic [SRAM_DATA_W-1:0]         SRAM_write_data_o,
    output logic                           SRAM_we_n_o,
    input  logic [SRAM_DATA_W-1:0]         SRAM_read_data_i
);

    localparam int BURST_W = $clog2(MAX_BURST + 1);
    localparam int TAG_N   = READ_LATENCY - 1;

    arb_state_t             state_q, state_d;
    logic [2:0]             owner_q, owner_d;
    logic [2:0]             ptr_q, ptr_d;
    logic [BURST_W-1:0]     burst_q, burst_d;
    logic [SRAM_ADDR_W-1:0] addr_q, addr_d;
    logic [SRAM_DATA_W-1:0] wdata_q, wdata_d;
    logic                   we_n_q, we_n_d;
    rd_tag_t [TAG_N-1:0]    tag_q, tag_d;
    logic [NUM_REQ-1:0]     rvalid_q, rvalid_d;
    logic [SRAM_DATA_W-1:0] rdata_q, rdata_d;

    logic [NUM_REQ-1:0]     grant;
    logic [NUM_REQ-1:0]     owner_oh;
    logic                   owner_req;
    logic                   others_req;
    logic [2:0]             pick_ptr;
    logic [NUM_REQ-1:0]     pick_oh;
    logic [2:0]             pick_idx;
    logic                   pick_any;

    // While owning, search from the owner so it is the last candidate;
    // that makes rotation and handover the same picker lookup.
    assign pick_ptr = (state_q == S_ARB_OWN) ? owner_q : ptr_q;

    sram_arb_rr_pick #(
        .NUM_REQ (NUM_REQ)
    ) u_pick (
        .req_i  (req_i),
        .ptr_i  (pick_ptr),
        .pick_o (pick_oh),
        .idx_o  (pick_idx),
        .any_o  (pick_any)
    );

    assign owner_oh   = NUM_REQ'(1) << owner_q;
    assign owner_req  = |(req_i & owner_oh);
    assign others_req = |(req_i & ~owner_oh);

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        ptr_d   = ptr_q;
        burst_d = burst_q;
        grant   = '0;
        case (state_q)
            S_ARB_IDLE: begin
                if (pick_any) begin
                    grant   = pick_oh;
                    owner_d = pick_idx;
                    burst_d = BURST_W'(1);
                    state_d = S_ARB_OWN;
                end
            end
            S_ARB_OWN: begin
                if (owner_req && ((burst_q < BURST_W'(MAX_BURST)) || !others_req)) begin
                    grant = owner_oh;
                    // Saturates at MAX_BURST when nobody else is waiting.
                    if (burst_q < BURST_W'(MAX_BURST)) begin
                        burst_d = burst_q + BURST_W'(1);
                    end
                end else begin
                    // Owner dropped or burst expired with a contender waiting.
                    ptr_d = owner_q;
                    if (pick_any) begin
                        grant   = pick_oh;
                        owner_d = pick_idx;
                        burst_d = BURST_W'(1);
                    end else begin
                        state_d = S_ARB_IDLE;
                    end
                end
            end
            default: state_d = S_ARB_IDLE;
        endcase
        if (Reset) begin
            grant = '0;
        end
    end

    assign grant_o = grant;

    // Grant is one-hot, so at most one requester's fields are selected.
    always_comb begin
        addr_d  = addr_q;
        wdata_d = wdata_q;
        we_n_d  = 1'b1;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                addr_d  = addr_i[i*SRAM_ADDR_W +: SRAM_ADDR_W];
                wdata_d = wdata_i[i*SRAM_DATA_W +: SRAM_DATA_W];
                we_n_d  = we_n_i[i];
            end
        end
    end

    always_comb begin
        tag_d          = tag_q;
        tag_d[0].valid = (|grant) && we_n_d;
        tag_d[0].idx   = owner_d;
        for (int i = 1; i < TAG_N; i++) begin
            tag_d[i] = tag_q[i-1];
        end
        rvalid_d = '0;
        rdata_d  = rdata_q;
        if (tag_q[TAG_N-1].valid) begin
            rvalid_d = NUM_REQ'(1) << tag_q[TAG_N-1].idx;
            rdata_d  = SRAM_read_data_i;
        end
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q  <= S_ARB_IDLE;
            owner_q  <= '0;
            ptr_q    <= 3'(NUM_REQ - 1);
            burst_q  <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
            we_n_q   <= 1'b1;
            tag_q    <= '0;
            rvalid_q <= '0;
            rdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            ptr_q    <= ptr_d;
            burst_q  <= burst_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            we_n_q   <= we_n_d;
            tag_q    <= tag_d;
            rvalid_q <= rvalid_d;
            rdata_q  <= rdata_d;
        end
    end

    assign rvalid_o          = rvalid_q;
    assign rdata_o           = rdata_q;
    assign owner_o           = owner_q;
    assign SRAM_address_o    = addr_q;
    assign SRAM_write_data_o = wdata_q;
    assign SRAM_we_n_o       = we_n_q;

endmodule

// File: tb/tb_sram_access_arbiter.sv
module tb_sram_access_arbiter;

    logic        Clock;
    logic        Reset;
    logic [3:0]  req_i;
    logic [3:0]  we_n_i;
    logic [71:0] addr_i;
    logic [63:0] wdata_i;
    logic [3:0]  grant_o;
    logic [3:0]  rvalid_o;
    logic [15:0] rdata_o;
    logic [2:0]  owner_o;
    logic [17:0] SRAM_address_o;
    logic [15:0] SRAM_write_data_o;
    logic        SRAM_we_n_o;
    logic [15:0] SRAM_read_data_i;

    logic [15:0] mem [0:262143];

    int errs   = 0;
    int checks = 0;

    sram_access_arbiter #(
        .NUM_REQ      (4),
        .MAX_BURST    (8),
        .READ_LATENCY (3)
    ) dut (
        .Clock             (Clock),
        .Reset             (Reset),
        .req_i             (req_i),
        .we_n_i            (we_n_i),
        .addr_i            (addr_i),
        .wdata_i           (wdata_i),
        .grant_o           (grant_o),
        .rvalid_o          (rvalid_o),
        .rdata_o           (rdata_o),
        .owner_o           (owner_o),
        .SRAM_address_o    (SRAM_address_o),
        .SRAM_write_data_o (SRAM_write_data_o),
        .SRAM_we_n_o       (SRAM_we_n_o),
        .SRAM_read_data_i  (SRAM_read_data_i)
    );

    initial begin
        Clock = 1'b0;
        forever #5 Clock = ~Clock;
    end

    // SRAM model: one-cycle registered read, write on we_n low.
    always @(posedge Clock) begin
        SRAM_read_data_i <= mem[SRAM_address_o];
        if (!SRAM_we_n_o) mem[SRAM_address_o] <= SRAM_write_data_o;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    initial begin
        for (int i = 0; i < 262144; i++) mem[i] = 16'h0000;
        mem[18'h00100] = 16'hBEEF;
        mem[18'h00200] = 16'h1111;
        mem[18'h00201] = 16'h2222;
        SRAM_read_data_i = 16'h0000;

        Reset   = 1'b1;
        req_i   = 4'hF;
        we_n_i  = 4'hF;
        addr_i  = '0;
        wdata_i = '0;

        // 1: reset held with all requests high
        repeat (3) tick();
        #1;
        chk("rst_grant", 32'(grant_o), 32'h0);
        chk("rst_rvalid", 32'(rvalid_o), 32'h0);
        chk("rst_rdata", 32'(rdata_o), 32'h0);
        chk("rst_owner", 32'(owner_o), 32'h0);
        chk("rst_addr", 32'(SRAM_address_o), 32'h0);
        chk("rst_wdata", 32'(SRAM_write_data_o), 32'h0);
        chk("rst_we_n", 32'(SRAM_we_n_o), 32'h1);
        Reset = 1'b0;
        req_i = 4'h0;
        tick();

        // 2: single read by requester 1
        req_i = 4'b0010;
        addr_i[1*18 +: 18] = 18'h00100;
        #1;
        chk("rd_grant_t0", 32'(grant_o), 32'b0010);
        tick();
        req_i = 4'b0000;
        #1;
        chk("rd_addr_t1", 32'(SRAM_address_o), 32'h00100);
        chk("rd_we_n_t1", 32'(SRAM_we_n_o), 32'h1);
        chk("rd_rvalid_t1", 32'(rvalid_o), 32'h0);
        tick();
        chk("rd_rvalid_t2", 32'(rvalid_o), 32'h0);
        tick();
        chk("rd_rvalid_t3", 32'(rvalid_o), 32'b0010);
        chk("rd_rdata_t3", 32'(rdata_o), 32'hBEEF);
        tick();
        chk("rd_rvalid_t4", 32'(rvalid_o), 32'h0);

        // 3: fresh reset, two requesters arrive together
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        req_i = 4'b0101;
        #1;
        chk("rr_first", 32'(grant_o), 32'b0001);
        tick();
        req_i = 4'b0100;
        #1;
        chk("rr_handover", 32'(grant_o), 32'b0100);
        tick();
        req_i = 4'b0000;
        #1;
        chk("rr_owner", 32'(owner_o), 32'h2);
        tick();

        // 4: burst limit, requester 2 arrives at cycle 2
        for (int c = 0; c < 8; c++) begin
            req_i = (c >= 2) ? 4'b0110 : 4'b0010;
            #1;
            chk($sformatf("burst1_c%0d", c), 32'(grant_o), 32'b0010);
            tick();
        end
        for (int c = 8; c < 11; c++) begin
            req_i = 4'b0110;
            #1;
            chk($sformatf("burst2_c%0d", c), 32'(grant_o), 32'b0100);
            tick();
        end
        req_i = 4'b0010;
        #1;
        chk("burst_resume1", 32'(grant_o), 32'b0010);
        tick();
        req_i = 4'b0000;
        #1;
        chk("burst_owner1", 32'(owner_o), 32'h1);
        tick();

        // 5: write by requester 2
        req_i  = 4'b0100;
        we_n_i = 4'b1011;
        addr_i[2*18 +: 18]  = 18'd146944;
        wdata_i[2*16 +: 16] = 16'h1234;
        #1;
        chk("wr_grant", 32'(grant_o), 32'b0100);
        tick();
        req_i  = 4'b0000;
        we_n_i = 4'b1111;
        #1;
        chk("wr_we_n_t1", 32'(SRAM_we_n_o), 32'h0);
        chk("wr_addr_t1", 32'(SRAM_address_o), 32'd146944);
        chk("wr_data_t1", 32'(SRAM_write_data_o), 32'h1234);
        tick();
        chk("wr_we_n_t2", 32'(SRAM_we_n_o), 32'h1);
        chk("wr_addr_hold", 32'(SRAM_address_o), 32'd146944);
        chk("wr_rvalid_t2", 32'(rvalid_o), 32'h0);
        tick();
        chk("wr_rvalid_t3", 32'(rvalid_o), 32'h0);
        tick();
        chk("wr_rvalid_t4", 32'(rvalid_o), 32'h0);

        // 6: two reads by requester 3, then reset drops them
        req_i = 4'b1000;
        addr_i[3*18 +: 18] = 18'h00200;
        #1;
        chk("rst_rd_grant0", 32'(grant_o), 32'b1000);
        tick();
        addr_i[3*18 +: 18] = 18'h00201;
        #1;
        chk("rst_rd_grant1", 32'(grant_o), 32'b1000);
        tick();
        req_i = 4'b0000;
        Reset = 1'b1;
        #1;
        chk("rst_mid_grant", 32'(grant_o), 32'h0);
        tick();
        Reset = 1'b0;
        for (int c = 0; c < 6; c++) begin
            chk($sformatf("rst_drop_c%0d", c), 32'(rvalid_o), 32'h0);
            tick();
        end
        chk("rst_drop_owner", 32'(owner_o), 32'h0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
